// File: rtl/serial_mod_pkg.sv
// Shared types and parameter defaults for the serial modulo checker.
package serial_mod_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StErr  = 2'd2
  } state_e;

  localparam int unsigned DefaultDw = 8;
  localparam int unsigned DefaultCw = 16;

endpackage

// File: rtl/mod_step.sv
// One MSB-first step of a running remainder: rem_next = (2*rem + in_bit) mod d.
// Relies on rem < d, so a single conditional subtract is enough.
module mod_step
  import serial_mod_pkg::*;
#(
  parameter int unsigned DW = DefaultDw
) (
  input  logic [DW-1:0] rem,
  input  logic          in_bit,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] rem_next
);

  logic [DW:0] w_t;
  logic        w_ge;

  // Shift in the new bit at DW+1 bits, then reduce once against d.
  always_comb begin
    w_t  = {rem, in_bit};
    w_ge = (w_t >= {1'b0, d});
    // When w_t >= d the true difference is < d, so DW-bit wraparound is exact.
    rem_next = w_ge ? (w_t[DW-1:0] - d) : w_t[DW-1:0];
  end

endmodule

// File: rtl/serial_mod_checker.sv
// Serial divisibility checker: consumes a number MSB first and tracks its
// remainder modulo a divisor latched at frame start.
module serial_mod_checker
  import serial_mod_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned CW = DefaultCw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] divisor,
  input  logic          in_valid,
  input  logic          in_bit,
  output logic          in_ready,
  output logic [DW-1:0] rem,
  output logic          divisible,
  output logic [CW-1:0] bit_cnt,
  output logic          out_valid,
  output logic          err
);

  state_e        r_state;
  state_e        w_state_next;
  logic [DW-1:0] r_div;
  logic [DW-1:0] r_rem;
  logic [DW-1:0] w_rem_next;
  logic [CW-1:0] r_cnt;
  logic          r_out_valid;
  logic          w_accept;

  // start always wins over a coincident bit, which is then dropped.
  assign w_accept = in_valid && (r_state == StRun) && !start;

  mod_step #(
    .DW(DW)
  ) u_mod_step (
    .rem     (r_rem),
    .in_bit  (in_bit),
    .d       (r_div),
    .rem_next(w_rem_next)
  );

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    err          = 1'b0;
    divisible    = 1'b0;
    if (start) begin
      w_state_next = (divisor == '0) ? StErr : StRun;
    end
    unique case (r_state)
      StRun:   begin
        in_ready  = 1'b1;
        divisible = (r_cnt != '0) && (r_rem == '0);
      end
      StErr:   err = 1'b1;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Divisor latch, remainder, saturating bit counter and accept strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (start) begin
        // A zero divisor only flags the error; frame state is kept as is.
        if (divisor != '0) begin
          r_div <= divisor;
          r_rem <= '0;
          r_cnt <= '0;
        end
      end else if (w_accept) begin
        r_rem <= w_rem_next;
        if (r_cnt != '1) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign rem       = r_rem;
  assign bit_cnt   = r_cnt;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_serial_mod_checker.sv
// Bench for serial_mod_checker: directed scenarios plus random traffic, all
// compared against an arithmetic model of the accepted number modulo divisor.
module tb_serial_mod_checker;

  localparam int MIdle = 0;
  localparam int MRun  = 1;
  localparam int MErr  = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  divisor;
  logic        in_valid;
  logic        in_bit;
  logic        in_ready,  in_ready2;
  logic [7:0]  rem,       rem2;
  logic        divisible, divisible2;
  logic [15:0] bit_cnt;
  logic [1:0]  bit_cnt2;
  logic        out_valid, out_valid2;
  logic        err,       err2;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model state.
  int m_state, m_div, m_rem, m_cnt, m_cnt2;
  bit m_ov;

  serial_mod_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .divisor(divisor),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready), .rem(rem),
    .divisible(divisible), .bit_cnt(bit_cnt), .out_valid(out_valid), .err(err)
  );

  serial_mod_checker #(.DW(8), .CW(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .start(start), .divisor(divisor),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready2), .rem(rem2),
    .divisible(divisible2), .bit_cnt(bit_cnt2), .out_valid(out_valid2), .err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = MIdle; m_div = 0; m_rem = 0; m_cnt = 0; m_cnt2 = 0; m_ov = 0;
  endtask

  task automatic model_edge(input bit st, input int dv, input bit v, input bit b);
    m_ov = 0;
    if (st) begin
      if (dv == 0) m_state = MErr;
      else begin
        m_state = MRun; m_div = dv; m_rem = 0; m_cnt = 0; m_cnt2 = 0;
      end
    end else if (v && m_state == MRun) begin
      m_rem = (m_rem * 2 + int'(b)) % m_div;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
      m_ov = 1;
    end
  endtask

  task automatic check_all(input string tag);
    bit run;
    run = (m_state == MRun);
    chk({tag, ".in_ready"},   in_ready,   run);
    chk({tag, ".err"},        err,        m_state == MErr);
    chk({tag, ".rem"},        rem,        m_rem);
    chk({tag, ".divisible"},  divisible,  run && m_cnt != 0 && m_rem == 0);
    chk({tag, ".bit_cnt"},    bit_cnt,    m_cnt);
    chk({tag, ".out_valid"},  out_valid,  m_ov);
    chk({tag, ".c2.bit_cnt"}, bit_cnt2,   m_cnt2);
    chk({tag, ".c2.rem"},     rem2,       m_rem);
    chk({tag, ".c2.div"},     divisible2, run && m_cnt2 != 0 && m_rem == 0);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check just after.
  task automatic step(input bit st, input int dv, input bit v, input bit b, input string tag);
    start = st; divisor = dv[7:0]; in_valid = v; in_bit = b;
    @(posedge clk);
    model_edge(st, dv, v, b);
    #1;
    check_all(tag);
  endtask

  initial begin
    bit   bits5 [4] = '{1, 0, 1, 0};
    int   rem5  [4] = '{1, 2, 0, 0};
    bit   div5  [4] = '{0, 0, 1, 1};
    bit   bits36[5] = '{1, 0, 1, 1, 0};
    int   pulses;

    rst_n = 1'b0; start = 0; divisor = '0; in_valid = 0; in_bit = 0;
    model_reset();
    #2;
    check_all("rst.async");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst.held");
    #2 rst_n = 1'b1;

    // No acceptance before the first start.
    step(0, 9, 1, 1, "idle.ign0");
    step(0, 9, 1, 1, "idle.ign1");

    // Divisor 5, bits 1,0,1,0.
    step(1, 5, 0, 0, "d5.start");
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 5, 1, bits5[i], "d5.bit");
      chk("d5.rem", rem, rem5[i]);
      chk("d5.divisible", divisible, div5[i]);
      chk("d5.bit_cnt", bit_cnt, i + 1);
      pulses += int'(out_valid);
    end
    step(0, 5, 0, 0, "d5.gap");
    chk("d5.pulses", pulses, 4);
    chk("d5.gap_ov", out_valid, 0);

    // Divisor 255: eight ones give 255, a ninth gives 511.
    step(1, 255, 0, 0, "d255.start");
    for (int i = 0; i < 8; i++) step(0, 255, 1, 1, "d255.bit");
    chk("d255.rem8", rem, 0);
    chk("d255.div8", divisible, 1);
    step(0, 255, 1, 1, "d255.bit9");
    chk("d255.rem9", rem, 1);

    // Zero divisor errors out and ignores bits; a good start recovers.
    step(1, 0, 0, 0, "d0.start");
    chk("d0.err", err, 1);
    chk("d0.in_ready", in_ready, 0);
    step(0, 0, 1, 1, "d0.ign0");
    step(0, 3, 1, 0, "d0.ign1");
    chk("d0.cnt_kept", bit_cnt, 9);
    step(1, 3, 0, 0, "d3.start");
    chk("d3.err", err, 0);
    step(0, 3, 1, 1, "d3.bit0");
    step(0, 3, 1, 1, "d3.bit1");
    chk("d3.rem", rem, 0);
    chk("d3.divisible", divisible, 1);

    // Start with in_valid mid-frame drops the bit.
    step(1, 7, 0, 0, "d7.start");
    step(0, 7, 1, 1, "d7.bit0");
    step(0, 7, 1, 1, "d7.bit1");
    step(1, 7, 1, 1, "d7.restart");
    chk("d7.rem", rem, 0);
    chk("d7.bit_cnt", bit_cnt, 0);
    chk("d7.out_valid", out_valid, 0);

    // CW=2 saturation with divisor 2.
    step(1, 2, 0, 0, "d2.start");
    for (int i = 0; i < 5; i++) step(0, 2, 1, bits36[i], "d2.bit");
    chk("d2.c2_cnt", bit_cnt2, 3);
    chk("d2.c2_rem", rem2, 0);
    chk("d2.cnt", bit_cnt, 5);

    // Divisor 1: always divisible once a bit is in.
    step(1, 1, 0, 0, "d1.start");
    step(0, 1, 1, 1, "d1.bit0");
    chk("d1.divisible", divisible, 1);
    step(0, 1, 1, 0, "d1.bit1");
    chk("d1.rem", rem, 0);

    // Asynchronous reset mid-frame with a bit pending.
    step(1, 5, 0, 0, "ar.start");
    step(0, 5, 1, 1, "ar.bit0");
    in_valid = 1; in_bit = 1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("ar.immediate");
    chk("ar.in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    check_all("ar.held");
    #2 rst_n = 1'b1;
    step(0, 5, 1, 1, "ar.ign0");
    step(0, 5, 1, 0, "ar.ign1");
    chk("ar.ov_none", out_valid, 0);
    step(1, 6, 0, 0, "ar.restart");
    step(0, 6, 1, 1, "ar.bit");
    chk("ar.after_ov", out_valid, 1);

    // Random traffic, including divisor wiggles without start.
    step(1, 13, 0, 0, "rnd.start");
    for (int i = 0; i < 400; i++) begin
      bit st, v, b;
      int dv;
      st = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) dv = 0;
      else if ($urandom_range(0, 1) == 0) dv = $urandom_range(1, 7);
      else dv = $urandom_range(1, 255);
      v = ($urandom_range(0, 3) != 0);
      b = 1'($urandom_range(0, 1));
      step(st, dv, v, b, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
